// File: rtl/lanectrl_pause_initiator_if.sv
// Clock-pause handshake bundle between the training sequencer, the pause
// initiator and the lane controller.
//   REQ             : 4-phase update request from the training sequencer
//   CODE_IN         : delay code to apply, sampled when REQ is accepted
//   ACK             : update complete, held until REQ falls
//   BUSY            : initiator is running a sequence
//   HS_IO_CLK_PAUSE : pause request towards the lane pause synchronizer
//   LOAD            : one-cycle strobe, CODE_OUT valid
//   CODE_OUT        : registered delay code presented to the lane controller
// master: training sequencer side; slave: pause initiator side.
interface lanectrl_pause_initiator_if #(
  parameter int CODE_W = 8
);
  logic              REQ;
  logic [CODE_W-1:0] CODE_IN;
  logic              ACK;
  logic              BUSY;
  logic              HS_IO_CLK_PAUSE;
  logic              LOAD;
  logic [CODE_W-1:0] CODE_OUT;

  modport master (
    output REQ,
    output CODE_IN,
    input  ACK,
    input  BUSY,
    input  HS_IO_CLK_PAUSE,
    input  LOAD,
    input  CODE_OUT
  );

  modport slave (
    input  REQ,
    input  CODE_IN,
    output ACK,
    output BUSY,
    output HS_IO_CLK_PAUSE,
    output LOAD,
    output CODE_OUT
  );
endinterface

// File: rtl/lanectrl_pause_initiator.sv
// Initiator side of the lane-controller clock-pause interface.
// On an accepted REQ it pauses the HS IO clock for SETUP_CYCLES, strobes
// LOAD for one cycle with the captured delay code, keeps the pause for
// HOLD_CYCLES, releases it, waits RECOVER_CYCLES and then raises ACK until
// REQ is withdrawn.
//   CLK   : fabric clock, all logic on the rising edge
//   RESET : asynchronous, active-high
//   bus   : handshake / pause / code bundle (slave side)
// Every output is a flop; the next-output logic decodes the next state so
// the outputs line up exactly with the state they belong to.
module lanectrl_pause_initiator #(
  parameter int SETUP_CYCLES   = 3,
  parameter int HOLD_CYCLES    = 2,
  parameter int RECOVER_CYCLES = 4,
  parameter int CODE_W         = 8
) (
  input logic                      CLK,
  input logic                      RESET,
  lanectrl_pause_initiator_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Counter preload values: a phase of N cycles starts at N-1 and the FSM
  // leaves the phase in the cycle the counter reads zero.
  localparam logic [7:0] SETUP_PRELOAD   = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] HOLD_PRELOAD    = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] RECOVER_PRELOAD = 8'(RECOVER_CYCLES - 1);

  state_t            state_r;
  state_t            state_s;
  logic [7:0]        cnt_r;
  logic [7:0]        cnt_s;
  logic [CODE_W-1:0] code_r;
  logic [CODE_W-1:0] code_s;
  logic              pause_r;
  logic              pause_s;
  logic              load_r;
  logic              load_s;
  logic              ack_r;
  logic              ack_s;
  logic              busy_r;
  logic              busy_s;

  // Next-state, counter, code capture and next-output decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    code_s  = code_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.REQ) begin
          state_s = ST_SETUP;
          cnt_s   = SETUP_PRELOAD;
          code_s  = bus.CODE_IN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_LOAD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_LOAD: begin
        state_s = ST_HOLD;
        cnt_s   = HOLD_PRELOAD;
      end
      ST_HOLD: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_RECOVER;
          cnt_s   = RECOVER_PRELOAD;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_r == 8'd0) begin
          state_s = ST_DONE;
        end else begin
          cnt_s = cnt_r - 8'd1;
        end
      end
      ST_DONE: begin
        // Only a withdrawn REQ ends the handshake, so a REQ left high can
        // never start a second sequence by itself.
        if (!bus.REQ) begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase

    // Pause covers SETUP, LOAD and HOLD only, so LOAD can never appear
    // without pause and never together with ACK.
    pause_s = (state_s == ST_SETUP) || (state_s == ST_LOAD) || (state_s == ST_HOLD);
    load_s  = (state_s == ST_LOAD);
    ack_s   = (state_s == ST_DONE);
    busy_s  = (state_s != ST_IDLE);
  end

  // State, counter, captured code and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      code_r  <= '0;
      pause_r <= 1'b0;
      load_r  <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      code_r  <= code_s;
      pause_r <= pause_s;
      load_r  <= load_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.HS_IO_CLK_PAUSE = pause_r;
  assign bus.LOAD            = load_r;
  assign bus.ACK             = ack_r;
  assign bus.BUSY            = busy_r;
  assign bus.CODE_OUT        = code_r;

endmodule
